// File: rtl/icache_line_fill.sv
// icache_line_fill: GSU instruction-cache miss handler; 8-byte line fills from ROM and uncached bypass fetches
module icache_line_fill (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cache_start,
  input  logic        lookup_valid,
  input  logic [15:0] pc,
  input  logic [5:0]  line_idx,
  input  logic        orange,
  input  logic        romrdy,
  input  logic [7:0]  rom_data,
  output logic        fetch_req,
  output logic [15:0] rom_addr,
  output logic        cram_we,
  output logic [8:0]  cram_addr,
  output logic [7:0]  cram_wdata,
  output logic [63:0] tag_valid,
  output logic        hit,
  output logic        stall,
  output logic        byp_valid,
  output logic [7:0]  byp_data,
  output logic        fill_done
);
  typedef enum logic [1:0] {IDLE, FILL, BYPASS, DRAIN} state_t;
  state_t     r_state;
  logic [5:0] r_idx;
  logic [2:0] r_cnt;
  logic       w_beat;
  assign w_beat     = fetch_req & romrdy;
  assign hit        = lookup_valid & ~orange & tag_valid[line_idx] & (r_state == IDLE);
  assign stall      = lookup_valid & ~hit & ~byp_valid;
  assign cram_we    = (r_state == FILL) & w_beat & ~cache_start;
  assign cram_addr  = {r_idx, r_cnt};
  assign cram_wdata = cram_we ? rom_data : 8'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      fetch_req <= 1'b0;
      rom_addr  <= '0;
      tag_valid <= '0;
      byp_valid <= 1'b0;
      byp_data  <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      byp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // the byp_valid cycle is the held request being answered, not a new one
          if (lookup_valid & ~byp_valid & orange) begin
            r_state   <= BYPASS;
            fetch_req <= 1'b1;
            rom_addr  <= pc;
          end else if (lookup_valid & ~byp_valid & ~tag_valid[line_idx]) begin
            r_state   <= FILL;
            fetch_req <= 1'b1;
            r_idx     <= line_idx;
            r_cnt     <= '0;
            rom_addr  <= {pc[15:3], 3'b000};
          end
        end
        FILL: begin
          if (w_beat & cache_start) begin
            r_state   <= IDLE;
            fetch_req <= 1'b0;
          end else if (w_beat) begin
            r_cnt    <= r_cnt + 3'd1;
            rom_addr <= {rom_addr[15:3], r_cnt + 3'd1};
            if (r_cnt == 3'd7) begin
              r_state          <= IDLE;
              fetch_req        <= 1'b0;
              tag_valid[r_idx] <= 1'b1;
              fill_done        <= 1'b1;
            end
          end else if (cache_start) r_state <= DRAIN;
        end
        BYPASS: begin
          if (w_beat) begin
            r_state   <= IDLE;
            fetch_req <= 1'b0;
            if (!cache_start) begin
              byp_data  <= rom_data;
              byp_valid <= 1'b1;
            end
          end else if (cache_start) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_beat) begin
            r_state   <= IDLE;
            fetch_req <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // flush overrides any valid bit set at this edge
      if (cache_start) tag_valid <= '0;
    end
  end
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: directed checks of fill, hit, bypass, flush and async reset
module tb_icache_line_fill;
  logic        clk, rst_n, cache_start, lookup_valid, orange, romrdy;
  logic [15:0] pc;
  logic [5:0]  line_idx;
  logic [7:0]  rom_data;
  logic        fetch_req, cram_we, hit, stall, byp_valid, fill_done;
  logic [15:0] rom_addr;
  logic [8:0]  cram_addr;
  logic [7:0]  cram_wdata, byp_data;
  logic [63:0] tag_valid;
  int          n_chk = 0;
  int          n_bad = 0;
  icache_line_fill dut (
    .clk(clk), .rst_n(rst_n), .cache_start(cache_start), .lookup_valid(lookup_valid),
    .pc(pc), .line_idx(line_idx), .orange(orange), .romrdy(romrdy), .rom_data(rom_data),
    .fetch_req(fetch_req), .rom_addr(rom_addr), .cram_we(cram_we), .cram_addr(cram_addr),
    .cram_wdata(cram_wdata), .tag_valid(tag_valid), .hit(hit), .stall(stall),
    .byp_valid(byp_valid), .byp_data(byp_data), .fill_done(fill_done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task step;
    @(posedge clk);
    #1;
  endtask
  task mid;
    @(negedge clk);
  endtask
  task miss(input logic [15:0] a, input logic [5:0] i);
    lookup_valid = 1; pc = a; line_idx = i; orange = 0; romrdy = 0;
    mid;
    chk("miss_stall", stall, 1);
    chk("miss_hit", hit, 0);
    chk("miss_req", fetch_req, 0);
    step;
    lookup_valid = 0;
  endtask
  task beat(input logic [2:0] b, input logic [15:0] base, input logic [5:0] i, input logic fl);
    logic [7:0] d;
    d = 8'h10 + {5'd0, b};
    romrdy = 1; rom_data = d; cache_start = fl;
    mid;
    chk("beat_req", fetch_req, 1);
    chk("beat_addr", rom_addr, base + {13'd0, b});
    chk("beat_we", cram_we, !fl);
    chk("beat_caddr", cram_addr, {i, b});
    chk("beat_wdata", cram_wdata, fl ? 8'h00 : d);
    chk("beat_done", fill_done, 0);
    step;
    romrdy = 0; cache_start = 0;
  endtask
  initial begin
    rst_n = 0; cache_start = 0; lookup_valid = 0; orange = 0; romrdy = 0;
    pc = 0; line_idx = 0; rom_data = 0;
    step;
    chk("rst_req", fetch_req, 0);
    chk("rst_tag", tag_valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_byp", {byp_valid, byp_data}, 0);
    chk("rst_we", cram_we, 0);
    chk("rst_done", fill_done, 0);
    rst_n = 1;
    step;
    // line fill then reissued hit
    miss(16'h0123, 6'd4);
    for (int b = 0; b < 8; b++) beat(b[2:0], 16'h0120, 6'd4, 0);
    lookup_valid = 1; pc = 16'h0123; line_idx = 6'd4;
    mid;
    chk("fill_done", fill_done, 1);
    chk("fill_tag", tag_valid, 64'h10);
    chk("fill_req_drop", fetch_req, 0);
    chk("hit", hit, 1);
    chk("hit_stall", stall, 0);
    step;
    mid;
    chk("done_pulse", fill_done, 0);
    chk("hit2", hit, 1);
    chk("hit_req", fetch_req, 0);
    step;
    // uncached bypass with 3 wait cycles
    lookup_valid = 1; orange = 1; pc = 16'h8000; line_idx = 0;
    mid;
    chk("byp_stall", stall, 1);
    chk("byp_hit", hit, 0);
    step;
    for (int w = 0; w < 3; w++) begin
      mid;
      chk("byp_wait_req", fetch_req, 1);
      chk("byp_wait_addr", rom_addr, 16'h8000);
      chk("byp_wait_valid", byp_valid, 0);
      step;
    end
    romrdy = 1; rom_data = 8'hA5;
    mid;
    chk("byp_rdy_req", fetch_req, 1);
    chk("byp_no_we", cram_we, 0);
    step;
    romrdy = 0;
    mid;
    chk("byp_valid", byp_valid, 1);
    chk("byp_data", byp_data, 8'hA5);
    chk("byp_unstall", stall, 0);
    chk("byp_req_drop", fetch_req, 0);
    step;
    lookup_valid = 0; orange = 0;
    mid;
    chk("byp_pulse", byp_valid, 0);
    chk("byp_hold", byp_data, 8'hA5);
    chk("byp_idle_req", fetch_req, 0);
    step;
    // flush after beat 3
    miss(16'h0200, 6'd9);
    for (int b = 0; b < 4; b++) beat(b[2:0], 16'h0200, 6'd9, 0);
    cache_start = 1;
    mid;
    chk("fl_req", fetch_req, 1);
    step;
    cache_start = 0;
    mid;
    chk("fl_tag", tag_valid, 0);
    chk("fl_req_held", fetch_req, 1);
    chk("fl_addr_held", rom_addr, 16'h0204);
    step;
    romrdy = 1; rom_data = 8'hEE;
    mid;
    chk("fl_drain_we", cram_we, 0);
    chk("fl_drain_req", fetch_req, 1);
    step;
    romrdy = 0;
    mid;
    chk("fl_req_drop", fetch_req, 0);
    chk("fl_no_done", fill_done, 0);
    chk("fl_no_byp", byp_valid, 0);
    step;
    // flush on the final beat
    miss(16'h0123, 6'd4);
    for (int b = 0; b < 7; b++) beat(b[2:0], 16'h0120, 6'd4, 0);
    beat(3'd7, 16'h0120, 6'd4, 1);
    mid;
    chk("fl7_done", fill_done, 0);
    chk("fl7_tag", tag_valid, 0);
    chk("fl7_req", fetch_req, 0);
    step;
    romrdy = 1;
    mid;
    chk("idle_rdy_we", cram_we, 0);
    chk("fl7_done2", fill_done, 0);
    step;
    romrdy = 0;
    // asynchronous reset mid-fill
    miss(16'h0040, 6'd8);
    beat(3'd0, 16'h0040, 6'd8, 0);
    beat(3'd1, 16'h0040, 6'd8, 0);
    mid;
    chk("ar_req_pre", fetch_req, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_req", fetch_req, 0);
    chk("ar_addr", rom_addr, 0);
    chk("ar_caddr", cram_addr, 0);
    chk("ar_tag", tag_valid, 0);
    #1 rst_n = 1;
    step;
    miss(16'h0040, 6'd8);
    for (int b = 0; b < 8; b++) beat(b[2:0], 16'h0040, 6'd8, 0);
    mid;
    chk("ar_fill_done", fill_done, 1);
    chk("ar_fill_tag", tag_valid, 64'h100);
    step;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
